// File: rtl/io_unit.sv
// User I/O block: OUT/IN instruction service with PC stall handshake, debounced insert,
// hex or signed-decimal seven-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
module io_unit #(
   parameter int DATA_W          = 32,
   parameter int SW_W            = 15,
   parameter int NUM_DIGITS      = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                    Clock,
   input  logic                    reset,
   input  logic                    halt,
   input  logic [DATA_W-1:0]       out_data,
   input  logic                    output_flag,
   input  logic                    input_flag,
   input  logic                    insert,
   input  logic [SW_W-1:0]         SW,
   input  logic                    disp_mode,
   output logic [DATA_W-1:0]       user_input,
   output logic                    io_stall,
   output logic                    overflow,
   output logic [7*NUM_DIGITS-1:0] HEX
);

   localparam int BCD_DIGITS  = (DATA_W * 30103 + 99999) / 100000;
   localparam int BCD_W       = 4 * BCD_DIGITS;
   localparam int EXT_DIGITS  = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
   localparam int EXT_W       = 4 * EXT_DIGITS;
   localparam int HEX_NIBBLES = DATA_W / 4;
   localparam int HX_DIGITS   = (NUM_DIGITS > HEX_NIBBLES) ? NUM_DIGITS : HEX_NIBBLES;
   localparam int HX_W        = 4 * HX_DIGITS;
   localparam int CNT_W       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int DB_W        = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   typedef enum logic [2:0] {
      IDLE, OUT_LOAD, CONVERT, IN_PRESS, IN_RELEASE, DONE
   } state_t;

   state_t                  state, state_next;
   logic [DB_W-1:0]         deb_cnt;
   logic                    deb_insert;
   logic [DATA_W-1:0]       result;
   logic [BCD_W-1:0]        bcd;
   logic                    neg;
   logic [CNT_W-1:0]        conv_cnt;
   logic                    conv_last;

   logic [BCD_W-1:0]        bcd_adj;
   logic [BCD_W-1:0]        bcd_step;
   logic [DATA_W-1:0]       bin_step;
   logic [EXT_W-1:0]        bcd_ext;
   logic [HX_W-1:0]         result_ext;
   logic [7*NUM_DIGITS-1:0] hex_disp;
   logic [7*NUM_DIGITS-1:0] dec_disp;
   logic                    dec_ovf;
   int unsigned             avail;
   int unsigned             msd;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 7'b1000000;
         4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;
         4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;
         4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;
         4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;
         4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;
         default: seg7 = 7'b0001110;
      endcase
   endfunction

   // Level flips only after DEBOUNCE_CYCLES consecutive samples that disagree with it
   always_ff @(posedge Clock) begin
      if (reset) begin
         deb_cnt    <= '0;
         deb_insert <= 1'b1;
      end else if (insert != deb_insert) begin
         if (deb_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_insert <= insert;
            deb_cnt    <= '0;
         end else begin
            deb_cnt <= deb_cnt + DB_W'(1);
         end
      end else begin
         deb_cnt <= '0;
      end
   end

   always_ff @(posedge Clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   assign conv_last = (conv_cnt == CNT_W'(DATA_W - 1));

   always_comb begin
      state_next = state;
      io_stall   = 1'b0;
      case (state)
         IDLE: begin
            if (!halt) begin
               if (output_flag)     state_next = OUT_LOAD;
               else if (input_flag) state_next = IN_PRESS;
            end
         end
         OUT_LOAD: begin
            io_stall   = 1'b1;
            state_next = disp_mode ? CONVERT : DONE;
         end
         CONVERT: begin
            io_stall = 1'b1;
            if (conv_last) state_next = DONE;
         end
         IN_PRESS: begin
            io_stall = 1'b1;
            if (!deb_insert) state_next = IN_RELEASE;
         end
         IN_RELEASE: begin
            io_stall = 1'b1;
            if (deb_insert) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One double-dabble step: bias BCD nibbles, then shift {bcd, binary} left together
   always_comb begin
      bcd_adj = bcd;
      for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      {bcd_step, bin_step} = {bcd_adj, result} << 1;
   end

   always_comb begin
      result_ext = HX_W'(result);
      hex_disp   = '1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (i < HEX_NIBBLES) hex_disp[7*i +: 7] = seg7(result_ext[4*i +: 4]);
      end
   end

   // Decimal view built from the final step's BCD so HEX updates on the last CONVERT edge
   always_comb begin
      bcd_ext  = EXT_W'(bcd_step);
      dec_disp = '1;
      dec_ovf  = 1'b0;
      msd      = 0;
      avail    = neg ? NUM_DIGITS - 1 : NUM_DIGITS;
      for (int unsigned i = 0; i < EXT_DIGITS; i++) begin
         if (i >= avail && bcd_ext[4*i +: 4] != 4'd0) dec_ovf = 1'b1;
      end
`ifdef LEADING_ZERO_BLANK_EN
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (i < avail && bcd_ext[4*i +: 4] != 4'd0) msd = i;
      end
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (i <= msd)                  dec_disp[7*i +: 7] = seg7(bcd_ext[4*i +: 4]);
         else if (neg && i == msd + 1)  dec_disp[7*i +: 7] = SEG_MINUS;
      end
`else
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (i < avail) dec_disp[7*i +: 7] = seg7(bcd_ext[4*i +: 4]);
         else           dec_disp[7*i +: 7] = SEG_MINUS;
      end
`endif
   end

   always_ff @(posedge Clock) begin
      if (reset) begin
         result     <= '0;
         bcd        <= '0;
         neg        <= 1'b0;
         conv_cnt   <= '0;
         user_input <= '0;
         overflow   <= 1'b0;
         HEX        <= '1;
      end else begin
         case (state)
            IDLE: begin
               if (!halt && output_flag) result <= out_data;
            end
            OUT_LOAD: begin
               if (!disp_mode) begin
                  HEX      <= hex_disp;
                  overflow <= 1'b0;
               end else begin
                  // 0x80..0 negates to itself, which is the correct unsigned magnitude
                  neg      <= result[DATA_W-1];
                  result   <= result[DATA_W-1] ? -result : result;
                  bcd      <= '0;
                  conv_cnt <= '0;
               end
            end
            CONVERT: begin
               result   <= bin_step;
               bcd      <= bcd_step;
               conv_cnt <= conv_cnt + CNT_W'(1);
               if (conv_last) begin
                  HEX      <= dec_disp;
                  overflow <= dec_ovf;
               end
            end
            IN_PRESS: begin
               if (!deb_insert) user_input <= DATA_W'($signed(SW));
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_io_unit.sv
// Directed self-checking bench for io_unit: hex/decimal output, overflow, debounced input,
// flag priority, halt, and reset during conversion.
module tb_io_unit;

   localparam int DATA_W = 32;
   localparam int SW_W   = 15;
   localparam int ND     = 8;
   localparam int DEB    = 4;

   localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
   localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00, S9 = 7'h10;
   localparam logic [6:0] SA = 7'h08, SB = 7'h03, SC = 7'h46, SD = 7'h21, SF = 7'h0E;
   localparam logic [6:0] SM = 7'h3F, BL = 7'h7F;

   logic              Clock = 1'b0;
   logic              reset, halt, output_flag, input_flag, insert, disp_mode;
   logic [DATA_W-1:0] out_data;
   logic [SW_W-1:0]   SW;
   logic [DATA_W-1:0] user_input;
   logic              io_stall, overflow;
   logic [7*ND-1:0]   HEX;

   int checks = 0;
   int errors = 0;
   int stalls;

   io_unit #(.DATA_W(DATA_W), .SW_W(SW_W), .NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DEB)) dut (
      .Clock(Clock), .reset(reset), .halt(halt), .out_data(out_data),
      .output_flag(output_flag), .input_flag(input_flag), .insert(insert), .SW(SW),
      .disp_mode(disp_mode), .user_input(user_input), .io_stall(io_stall),
      .overflow(overflow), .HEX(HEX)
   );

   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Counts stall-high negedges; returns at the first low sample after the stall (DONE)
   task automatic run_op(output int n);
      bit seen_low;
      n = 0;
      seen_low = 1'b0;
      for (int c = 0; c < 200 && !seen_low; c++) begin
         @(negedge Clock);
         if (io_stall) n++;
         else if (n > 0) seen_low = 1'b1;
      end
   endtask

   task automatic wait_release(output int n);
      bit seen_low;
      n = 0;
      seen_low = 1'b0;
      for (int c = 0; c < 100 && !seen_low; c++) begin
         @(negedge Clock);
         if (io_stall) n++;
         else seen_low = 1'b1;
      end
   endtask

   initial begin
      reset = 1'b1; halt = 1'b0; output_flag = 1'b0; input_flag = 1'b0;
      insert = 1'b1; disp_mode = 1'b0; out_data = '0; SW = '0;
      repeat (2) @(negedge Clock);
      check("rst_stall", io_stall, 0);
      check("rst_ovf", overflow, 0);
      check("rst_hex", HEX, {ND{BL}});
      check("rst_uin", user_input, 0);
      reset = 1'b0;
      @(negedge Clock);

      // Hex display
      disp_mode = 1'b0; out_data = 32'h1234ABCD; output_flag = 1'b1;
      run_op(stalls);
      output_flag = 1'b0;
      check("hex_stall", stalls, 1);
      check("hex_val", HEX, {S1, S2, S3, S4, SA, SB, SC, SD});
      check("hex_ovf", overflow, 0);
      @(negedge Clock);

      // Decimal -42
      disp_mode = 1'b1; out_data = 32'hFFFFFFD6; output_flag = 1'b1;
      run_op(stalls);
      output_flag = 1'b0;
      check("dec_stall", stalls, DATA_W + 1);
`ifdef LEADING_ZERO_BLANK_EN
      check("dec_m42", HEX, {BL, BL, BL, BL, BL, SM, S4, S2});
`else
      check("dec_m42", HEX, {SM, S0, S0, S0, S0, S0, S4, S2});
`endif
      check("dec_m42_ovf", overflow, 0);
      @(negedge Clock);

      // Decimal zero
      out_data = 32'h0; output_flag = 1'b1;
      run_op(stalls);
      output_flag = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      check("dec_zero", HEX, {BL, BL, BL, BL, BL, BL, BL, S0});
`else
      check("dec_zero", HEX, {S0, S0, S0, S0, S0, S0, S0, S0});
`endif
      check("dec_zero_ovf", overflow, 0);
      @(negedge Clock);

      // Most negative: -2147483648, only 7 digits available beside the sign
      out_data = 32'h80000000; output_flag = 1'b1;
      run_op(stalls);
      output_flag = 1'b0;
      check("dec_min", HEX, {SM, S7, S4, S8, S3, S6, S4, S8});
      check("dec_min_ovf", overflow, 1);
      @(negedge Clock);

      // Input with a short glitch, then a real press
      SW = 15'h4005; input_flag = 1'b1;
      @(negedge Clock);
      insert = 1'b0;
      repeat (2) @(negedge Clock);
      insert = 1'b1;
      @(negedge Clock);
      check("in_glitch_stall", io_stall, 1);
      check("in_glitch_uin", user_input, 0);
      insert = 1'b0;
      repeat (10) @(negedge Clock);
      check("in_held_stall", io_stall, 1);
      check("in_capture", user_input, 32'hFFFFC005);
      insert = 1'b1;
      wait_release(stalls);
      input_flag = 1'b0;
      check("in_release_cycles", stalls, DEB);
      check("in_done_stall", io_stall, 0);
      @(negedge Clock);

      // Both flags: decimal overflow output first, then the input
      disp_mode = 1'b1; out_data = 32'd123456789; SW = 15'h0123;
      output_flag = 1'b1; input_flag = 1'b1;
      run_op(stalls);
      output_flag = 1'b0;
      check("both_out_stall", stalls, DATA_W + 1);
      check("both_out_hex", HEX, {S2, S3, S4, S5, S6, S7, S8, S9});
      check("both_out_ovf", overflow, 1);
      insert = 1'b0;
      repeat (6) @(negedge Clock);
      check("both_in_stall", io_stall, 1);
      check("both_in_uin", user_input, 32'h00000123);
      insert = 1'b1;
      wait_release(stalls);
      input_flag = 1'b0;
      check("both_in_release", stalls, DEB);
      @(negedge Clock);

      // Halt: flags ignored, display and input held
      halt = 1'b1; output_flag = 1'b1; input_flag = 1'b1;
      disp_mode = 1'b0; out_data = 32'hFFFFFFFF;
      for (int c = 0; c < 5; c++) begin
         @(negedge Clock);
         check("halt_stall", io_stall, 0);
      end
      check("halt_hex", HEX, {S2, S3, S4, S5, S6, S7, S8, S9});
      check("halt_uin", user_input, 32'h00000123);
      halt = 1'b0; output_flag = 1'b0; input_flag = 1'b0;
      @(negedge Clock);

      // Reset in the middle of a conversion
      disp_mode = 1'b1; out_data = 32'hFFFFFFD6; output_flag = 1'b1;
      repeat (11) @(negedge Clock);
      check("conv_mid_stall", io_stall, 1);
      reset = 1'b1; output_flag = 1'b0;
      @(negedge Clock);
      check("conv_rst_stall", io_stall, 0);
      check("conv_rst_hex", HEX, {ND{BL}});
      check("conv_rst_ovf", overflow, 0);
      check("conv_rst_uin", user_input, 0);
      reset = 1'b0;
      @(negedge Clock);
      check("post_rst_stall", io_stall, 0);

      // Hex all-ones after reset
      disp_mode = 1'b0; out_data = 32'hFFFFFFFF; output_flag = 1'b1;
      run_op(stalls);
      output_flag = 1'b0;
      check("hex_ff_stall", stalls, 1);
      check("hex_ff", HEX, {ND{SF}});
      @(negedge Clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/io_unit.md
Name: io_unit

Overview:
- Parametrised next-generation user I/O block for the MIPS core: services the OUT and IN instructions, drives NUM_DIGITS seven-segment displays and captures switch input.
- Adds over the previous IO block: a stall handshake to the PC/ControlUnit, debounced insert handling, signed-decimal or hex display mode with iterative binary-to-BCD conversion, and an overflow indicator.
- Sits beside the Registers/PC: consumes ReadData1, output_flag, input_flag, halt; produces user_input for the writeData mux and io_stall for the PC hold.

Parameters:
DATA_W, 32, width of processor data word
SW_W, 15, number of slide switches captured on input
NUM_DIGITS, 8, number of seven-segment digits driven (2..10)
DEBOUNCE_CYCLES, 4, consecutive stable samples required on insert (>=1)

Ports:
Clock  input  1  system clock (divided processor clock)
reset  input  1  synchronous, active-high reset
halt  input  1  processor halted; freezes display and ignores flags
out_data  input  DATA_W  value to display (ReadData1)
output_flag  input  1  OUT instruction present
input_flag  input  1  IN instruction present
insert  input  1  raw pushbutton, active-low
SW  input  SW_W  slide switches
disp_mode  input  1  0 = hex, 1 = signed decimal
user_input  output  DATA_W  captured switch value, sign-extended from SW[SW_W-1]
io_stall  output  1  PC must hold while high
overflow  output  1  last decimal value did not fit the digits
HEX  output  7*NUM_DIGITS  active-low segments; digit i on bits [7i+6:7i], digit 0 least significant

Behaviour:
- Reset: FSM IDLE; user_input=0; io_stall=0; overflow=0; HEX all 1s (blank); debounce counter 0, debounced insert=1.
- Debounce: insert sampled each cycle; debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples differing from current level.
- States: IDLE, OUT_LOAD, CONVERT, IN_PRESS, IN_RELEASE, DONE.
- IDLE: io_stall=0. halt=1 -> stay, no flag acted on. output_flag=1 -> latch out_data into result register, go OUT_LOAD, io_stall=1 next cycle. input_flag=1 (output_flag=0) -> IN_PRESS. Both flags set -> output served first; input_flag taken after DONE returns to IDLE.
- io_stall is combinational from state: 1 in OUT_LOAD, CONVERT, IN_PRESS, IN_RELEASE; 0 in IDLE, DONE.
- OUT_LOAD: hex mode -> HEX digit i shows nibble i of value (digits beyond DATA_W/4 blank), overflow=0, go DONE (total stall 1 cycle). Decimal mode -> take magnitude (two's-complement negate if bit DATA_W-1 set, record sign), clear BCD shift register, go CONVERT.
- CONVERT: one double-dabble step per cycle (add 3 to each BCD nibble >=5, then shift left one bit); exactly DATA_W cycles, then update HEX: when negative, top digit shows '-' (7'b0111111) and lower NUM_DIGITS-1 digits show the value; positive uses all NUM_DIGITS. overflow=1 if any nonzero BCD digit lies beyond the available digits (lower digits still shown). Go DONE.
- Most negative value (0x80000000): negation leaves 0x80000000, treated as unsigned magnitude 2147483648; correct.
- IN_PRESS: wait for debounced insert=0; on it capture SW sign-extended into user_input, go IN_RELEASE.
- IN_RELEASE: wait for debounced insert=1, go DONE. Button held across instructions never double-captures.
- DONE: one cycle, io_stall=0 so PC advances on this edge; flags ignored; go IDLE.
- HEX and user_input hold between operations; halt does not clear them.
- reset mid-operation (any state, including CONVERT): immediate return to reset values at the next edge; partial conversion discarded.

Optional Feature:
LEADING_ZERO_BLANK_EN: defined -> in decimal mode, zero digits above the most significant nonzero digit are blanked (value 0 shows single '0' in digit 0); '-' sits in the digit immediately above the most significant digit. Undefined -> all digits shown with leading zeros, '-' fixed in the top digit.

Test Plan:
- Hex out: disp_mode=0, out_data=0x1234ABCD, output_flag pulse held while io_stall -> io_stall high exactly 1 cycle, HEX digits 7..0 = 1,2,3,4,A,B,C,D, overflow=0.
- Decimal out: disp_mode=1, out_data=-42 (0xFFFFFFD6) -> io_stall high DATA_W+1 cycles; digit 7='-', digits 1,0 = 4,2, digits 6..2 '0' (blank with LEADING_ZERO_BLANK_EN, '-' then in digit 2).
- Overflow: disp_mode=1, NUM_DIGITS=8, out_data=123456789 -> overflow=1, digits show 23456789.
- Input: input_flag=1, SW=15'h4005, insert low 2 cycles (glitch) then low 10 cycles then high -> no capture on glitch; user_input=0xFFFFC005 after debounce; io_stall drops only after release+DEBOUNCE_CYCLES, then one DONE cycle.
- Simultaneous flags with halt: output_flag=input_flag=1 -> output completes, then input served; with halt=1 in IDLE, flags ignored and HEX unchanged.
- Reset during CONVERT (cycle 10) -> next edge io_stall=0, HEX all blank, overflow=0, user_input=0.
